// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter
// Shares one toggle-handshake SDRAM controller port among four clients.
// Client 0 (video) has fixed top priority; clients 1..3 rotate round-robin.
// Each client's level req / one-cycle done handshake is turned into the
// controller's req-toggle / ack-follows protocol.
module sdram_port_arbiter #(
    parameter int TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  c_req,
    input  logic [3:0]  c_we,
    input  logic [91:0] c_a,
    input  logic [7:0]  c_ds,
    input  logic [63:0] c_d,
    output logic [15:0] c_q,
    output logic [3:0]  c_done,
    output logic [1:0]  grant,
    output logic        busy,
    output logic        timeout,
    output logic        mem_req,
    input  logic        mem_ack,
    output logic        mem_we,
    output logic [22:0] mem_a,
    output logic [1:0]  mem_ds,
    output logic [15:0] mem_d,
    input  logic [15:0] mem_q
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nx;
    logic [1:0]         rr_ptr;
    logic [CNT_W-1:0]   wait_cnt;
    logic [1:0]         winner;
    logic               ack_match;

    // Controller has caught up with our toggle: the outstanding cycle is complete.
    assign ack_match = (mem_ack == mem_req);

    // Round-robin successor among clients 1..3 (3 wraps back to 1).
    function automatic logic [1:0] rr_next(input logic [1:0] p);
        return (p == 2'd3) ? 2'd1 : p + 2'd1;
    endfunction

    // Winner selection: client 0 first, otherwise scan 1..3 from the rr pointer.
    always_comb begin
        logic [1:0] cand;
        logic       found;
        winner = rr_ptr;
        cand   = rr_ptr;
        found  = 1'b0;
        if (c_req[0]) begin
            winner = 2'd0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (!found && c_req[cand]) begin
                    winner = cand;
                    found  = 1'b1;
                end
                cand = rr_next(cand);
            end
        end
    end

    // Next-state logic for the IDLE -> ISSUE -> WAIT -> DONE transaction cycle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|c_req) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (ack_match) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Latched transaction, handshake toggle, completion pulse, rr pointer and timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            // Reloading mem_req from mem_ack resynchronises the toggle pair;
            // with mem_we cleared any cycle this provokes is a harmless read.
            mem_req  <= mem_ack;
            mem_we   <= 1'b0;
            mem_a    <= '0;
            mem_ds   <= 2'b00;
            mem_d    <= '0;
            c_q      <= '0;
            c_done   <= '0;
            grant    <= 2'd0;
            busy     <= 1'b0;
            timeout  <= 1'b0;
            rr_ptr   <= 2'd1;
            wait_cnt <= '0;
        end else begin
            c_done <= '0;
            case (state)
                IDLE: begin
                    if (|c_req) begin
                        grant  <= winner;
                        mem_we <= c_we[winner];
                        mem_a  <= c_a[23*winner +: 23];
                        mem_ds <= c_ds[2*winner +: 2];
                        mem_d  <= c_d[16*winner +: 16];
                        busy   <= 1'b1;
                    end
                end
                ISSUE: begin
                    mem_req  <= ~mem_req;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (wait_cnt != '1)
                        wait_cnt <= wait_cnt + 1'b1;
                    if (wait_cnt == CNT_W'(TIMEOUT - 1))
                        timeout <= 1'b1;
                    if (ack_match) begin
                        if (!mem_we) c_q <= mem_q;
                        c_done <= 4'b0001 << grant;
                        busy   <= 1'b0;
                    end
                end
                DONE: begin
                    if (grant != 2'd0) rr_ptr <= rr_next(grant);
                end
                default: ;
            endcase
        end
    end

endmodule
